// File: rtl/instruction_fetch_unit.sv
// Purpose: owns the PC, fetches instruction words over a req/ack handshake and strobes them into the IR.
// Latency: a request sampled in HOLD gives LOAD one edge later with zero-wait memory, plus one cycle per memory wait state.
// Backpressure: waits indefinitely for mem_ack; busy stays high until HOLD, and control requests are ignored meanwhile.
module instruction_fetch_unit #(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   mem_req,
    output logic [PC_WIDTH-1:0]    mem_addr,
    input  logic                   mem_ack,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic [INSTR_WIDTH-1:0] IR,
    output logic                   IL,
    input  logic                   next,
    input  logic                   branch_en,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic                   halt,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        LOAD   = 3'd2,
        HOLD   = 3'd3,
        HALTED = 3'd4
    } state_t;

    // Increment constant sized to the PC so the wrap at 2^PC_WIDTH is implicit.
    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_t                   state_q;
    state_t                   state_nxt;
    logic [PC_WIDTH-1:0]      pc_q;
    logic [PC_WIDTH-1:0]      pc_nxt;
    logic [INSTR_WIDTH-1:0]   ir_q;
    logic [INSTR_WIDTH-1:0]   ir_nxt;

    // State, PC and IR registers; reset discards any in-flight word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            ir_q    <= ir_nxt;
        end
    end

    // Next-state logic: IR and PC only move on the REQ ack edge or a HOLD branch.
    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q;
        ir_nxt    = ir_q;
        case (state_q)
            IDLE: begin
                state_nxt = REQ;
            end
            REQ: begin
                if (mem_ack) begin
                    ir_nxt    = mem_rdata;
                    pc_nxt    = pc_q + PC_ONE;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                // halt beats branch beats sequential fetch
                if (halt) begin
                    state_nxt = HALTED;
                end else if (branch_en) begin
                    pc_nxt    = branch_target;
                    state_nxt = REQ;
                end else if (next) begin
                    state_nxt = REQ;
                end
            end
            HALTED: begin
                state_nxt = HALTED;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Handshake and strobe outputs decode straight from the registered state, so they are glitch-free.
    assign mem_req  = (state_q == REQ);
    assign IL       = (state_q == LOAD);
    assign busy     = (state_q == IDLE) || (state_q == REQ) || (state_q == LOAD);
    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign IR       = ir_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Purpose: directed checks of the fetch unit with a scoreboard that checks every IL strobe against queued expectations.
// Latency: the memory responder answers after a programmable number of wait cycles.
// Backpressure: the responder can stall REQ for any number of cycles or force a stray ack.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ir;
    logic        il;
    logic        next;
    logic        branch_en;
    logic [7:0]  branch_target;
    logic        halt;
    logic [7:0]  pc;
    logic        busy;

    int checks = 0;
    int passes = 0;

    logic [15:0] mem [256];
    int          wait_cycles = 0;
    int          wait_cnt    = 0;
    logic        ack_force   = 1'b0;

    logic [15:0] exp_ir_q [$];
    logic [7:0]  exp_pc_q [$];

    instruction_fetch_unit #(
        .PC_WIDTH    (8),
        .INSTR_WIDTH (16),
        .RESET_PC    (8'h00)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .IR            (ir),
        .IL            (il),
        .next          (next),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .halt          (halt),
        .pc            (pc),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_fetch(input logic [15:0] exp_ir, input logic [7:0] exp_pc);
        exp_ir_q.push_back(exp_ir);
        exp_pc_q.push_back(exp_pc);
    endtask

    // One-cycle control request issued from HOLD.
    task automatic issue(input logic nx, input logic br, input logic hl, input logic [7:0] tgt);
        next          = nx;
        branch_en     = br;
        halt          = hl;
        branch_target = tgt;
        step();
        next      = 1'b0;
        branch_en = 1'b0;
        halt      = 1'b0;
    endtask

    // Called in the first REQ cycle: checks the address, waits for LOAD, then expects HOLD.
    task automatic finish_fetch(input logic [7:0] addr);
        int n;
        chk("req_high", {31'd0, mem_req}, 32'd1);
        chk("req_addr", {24'd0, mem_addr}, {24'd0, addr});
        n = 0;
        while (il !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("il_seen", {31'd0, il}, 32'd1);
        step();
        chk("hold_busy", {31'd0, busy}, 32'd0);
        chk("hold_il", {31'd0, il}, 32'd0);
    endtask

    // Memory model: answers REQ after wait_cycles stalled cycles; drives shortly after the falling edge.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
        forever begin
            @(negedge clk);
            #1;
            if (ack_force) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'hDEAD;
                wait_cnt  = 0;
            end else if (mem_req === 1'b1) begin
                if (wait_cnt < wait_cycles) begin
                    mem_ack   = 1'b0;
                    mem_rdata = 16'hDEAD;
                    wait_cnt++;
                end else begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                    wait_cnt  = 0;
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'hDEAD;
                wait_cnt  = 0;
            end
        end
    end

    // Scoreboard monitor: every IL strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (il === 1'b1) begin
            if (exp_ir_q.size() == 0) begin
                chk("unexpected_il", {31'd0, il}, 32'd0);
            end else begin
                chk("sb_ir", {16'd0, ir}, {16'd0, exp_ir_q.pop_front()});
                chk("sb_pc", {24'd0, pc}, {24'd0, exp_pc_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hC000 | 16'(i);
        mem[8'h00] = 16'h1234;
        mem[8'h01] = 16'hBEEF;
        mem[8'hFE] = 16'h0FE0;
        mem[8'hFF] = 16'hA5A5;
        mem[8'h40] = 16'h4040;
        mem[8'h41] = 16'h4141;

        reset         = 1'b1;
        next          = 1'b0;
        branch_en     = 1'b0;
        branch_target = 8'h00;
        halt          = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_il", {31'd0, il}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_pc", {24'd0, pc}, 32'd0);
        chk("rst_ir", {16'd0, ir}, 32'd0);

        // Automatic first fetch, zero-wait memory
        expect_fetch(16'h1234, 8'h01);
        reset = 1'b0;
        step();
        chk("c1_req", {31'd0, mem_req}, 32'd1);
        chk("c1_busy", {31'd0, busy}, 32'd1);
        chk("c1_il", {31'd0, il}, 32'd0);
        chk("c1_addr", {24'd0, mem_addr}, 32'd0);
        step();
        chk("c2_il", {31'd0, il}, 32'd1);
        chk("c2_busy", {31'd0, busy}, 32'd1);
        step();
        chk("c3_il", {31'd0, il}, 32'd0);
        chk("c3_busy", {31'd0, busy}, 32'd0);
        chk("c3_req", {31'd0, mem_req}, 32'd0);
        chk("c3_pc", {24'd0, pc}, 32'h01);
        chk("c3_ir", {16'd0, ir}, 32'h1234);

        // Three memory wait cycles
        wait_cycles = 3;
        expect_fetch(16'hBEEF, 8'h02);
        issue(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            chk("wait_req", {31'd0, mem_req}, 32'd1);
            chk("wait_il", {31'd0, il}, 32'd0);
            chk("wait_addr", {24'd0, mem_addr}, 32'h01);
            step();
        end
        finish_fetch(8'h01);
        chk("wait_pc", {24'd0, pc}, 32'h02);

        // PC wrap: reach 0xFF by branching to 0xFE, then fetch sequentially
        wait_cycles = 0;
        expect_fetch(16'h0FE0, 8'hFF);
        issue(1'b0, 1'b1, 1'b0, 8'hFE);
        finish_fetch(8'hFE);
        chk("pre_wrap_pc", {24'd0, pc}, 32'hFF);
        expect_fetch(16'hA5A5, 8'h00);
        issue(1'b1, 1'b0, 1'b0, 8'h00);
        finish_fetch(8'hFF);
        chk("wrap_pc", {24'd0, pc}, 32'h00);

        // branch_en wins over next
        expect_fetch(16'h4040, 8'h41);
        issue(1'b1, 1'b1, 1'b0, 8'h40);
        finish_fetch(8'h40);
        chk("branch_pc", {24'd0, pc}, 32'h41);

        // Requests while busy, and stray ack in HOLD, are ignored
        wait_cycles = 2;
        expect_fetch(16'h4141, 8'h42);
        issue(1'b1, 1'b0, 1'b0, 8'h00);
        next = 1'b1; branch_en = 1'b1; halt = 1'b1; branch_target = 8'h10;
        step();
        next = 1'b0; branch_en = 1'b0; halt = 1'b0;
        chk("busy_req", {31'd0, mem_req}, 32'd1);
        chk("busy_addr", {24'd0, mem_addr}, 32'h41);
        step();
        chk("busy_req2", {31'd0, mem_req}, 32'd1);
        step();
        chk("busy_load_il", {31'd0, il}, 32'd1);
        next = 1'b1; branch_en = 1'b1;
        step();
        next = 1'b0; branch_en = 1'b0;
        chk("busy_hold", {31'd0, busy}, 32'd0);
        chk("busy_pc", {24'd0, pc}, 32'h42);
        chk("busy_ir", {16'd0, ir}, 32'h4141);
        ack_force = 1'b1;
        step();
        ack_force = 1'b0;
        chk("stray_ack_busy", {31'd0, busy}, 32'd0);
        chk("stray_ack_req", {31'd0, mem_req}, 32'd0);
        chk("stray_ack_il", {31'd0, il}, 32'd0);
        chk("stray_ack_pc", {24'd0, pc}, 32'h42);
        chk("stray_ack_ir", {16'd0, ir}, 32'h4141);

        // halt beats branch_en; HALTED ignores everything
        issue(1'b0, 1'b1, 1'b1, 8'h80);
        chk("halt_req", {31'd0, mem_req}, 32'd0);
        chk("halt_busy", {31'd0, busy}, 32'd0);
        chk("halt_pc", {24'd0, pc}, 32'h42);
        for (int i = 0; i < 3; i++) begin
            next = 1'b1; branch_en = 1'b1; branch_target = 8'h20;
            step();
            next = 1'b0; branch_en = 1'b0;
            chk("halted_req", {31'd0, mem_req}, 32'd0);
            chk("halted_pc", {24'd0, pc}, 32'h42);
            chk("halted_il", {31'd0, il}, 32'd0);
        end

        // Reset out of HALTED, then reset again in the middle of a stalled REQ
        wait_cycles = 5;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("unhalt_ir", {16'd0, ir}, 32'd0);
        chk("unhalt_pc", {24'd0, pc}, 32'd0);
        step();
        chk("mid_req", {31'd0, mem_req}, 32'd1);
        chk("mid_addr", {24'd0, mem_addr}, 32'd0);
        reset = 1'b1;
        step();
        reset     = 1'b0;
        ack_force = 1'b1;
        chk("midrst_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd1);
        chk("midrst_ir", {16'd0, ir}, 32'd0);
        chk("midrst_pc", {24'd0, pc}, 32'd0);
        step();
        ack_force   = 1'b0;
        wait_cycles = 0;
        chk("late_ack_ir", {16'd0, ir}, 32'd0);
        chk("late_ack_pc", {24'd0, pc}, 32'd0);
        chk("late_ack_il", {31'd0, il}, 32'd0);
        expect_fetch(16'h1234, 8'h01);
        finish_fetch(8'h00);
        chk("refetch_pc", {24'd0, pc}, 32'h01);
        chk("refetch_ir", {16'd0, ir}, 32'h1234);

        step();
        chk("sb_drained", exp_ir_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Upstream fetch stage for the 16-bit datapath. It owns the program counter and issues reads to instruction memory over a req/ack handshake. It presents each fetched word on `IR` with a one-cycle `IL` strobe to the instruction register, then waits for the control unit to request the next instruction, branch, or halt.

## Interface
Parameters:
- `PC_WIDTH`, default 8: program counter and memory address width.
- `INSTR_WIDTH`, default 16: instruction word width.
- `RESET_PC`, default 0: PC value loaded on reset.

Ports:
- `clk`, input, 1: system clock. All state updates on the rising edge.
- `reset`, input, 1: reset, synchronous, active-high.
- `mem_req`, output, 1: read request to instruction memory.
- `mem_addr`, output, PC_WIDTH: read address. Equals `pc`.
- `mem_ack`, input, 1: memory has valid `mem_rdata` this cycle.
- `mem_rdata`, input, INSTR_WIDTH: read data. Valid only when `mem_ack`=1.
- `IR`, output, INSTR_WIDTH: instruction to the instruction register.
- `IL`, output, 1: instruction load strobe to the instruction register.
- `next`, input, 1: control unit requests a sequential fetch.
- `branch_en`, input, 1: control unit requests a fetch from `branch_target`.
- `branch_target`, input, PC_WIDTH: branch destination.
- `halt`, input, 1: stop fetching until reset.
- `pc`, output, PC_WIDTH: address of the next word to fetch.
- `busy`, output, 1: high while the unit cannot accept `next`, `branch_en` or `halt`.

## Operation
- States: IDLE, REQ, LOAD, HOLD, HALTED. All outputs except `IR` and `pc` decode directly from the registered state:
  - `mem_req` = (REQ)
  - `IL` = (LOAD)
  - `busy` = (IDLE, REQ or LOAD)
- Reset values: state=IDLE, `pc`=RESET_PC, `IR`=0, `IL`=0, `mem_req`=0, `busy`=1.
- IDLE: goes unconditionally to REQ on the next edge. This makes the first fetch automatic after reset.
- REQ: `mem_req`=1 and `mem_addr`=`pc`, both held stable until ack.
  - On an edge with `mem_ack`=1: `IR` <= `mem_rdata`, `pc` <= `pc`+1, go to LOAD.
  - Otherwise stay in REQ. Wait states are unbounded.
- PC increment is modulo 2^PC_WIDTH: 0xFF+1 = 0x00 for the default width. There is no overflow flag.
- LOAD: `IL`=1 for exactly one cycle with `IR` stable, then go to HOLD.
- HOLD: `IL`=0 and `IR` held. Requests are sampled with priority `halt` > `branch_en` > `next`:
  - `halt`: go to HALTED.
  - `branch_en`: `pc` <= `branch_target`, go to REQ.
  - `next`: go to REQ.
  - None asserted: stay in HOLD.
- HALTED: `mem_req`=0, `IL`=0, `busy`=0. Stays here until reset. `next`, `branch_en` and `halt` are ignored.
- `next`, `branch_en` and `halt` are ignored in IDLE, REQ and LOAD. The control unit must only assert them while `busy`=0.
- `mem_ack` is ignored outside REQ: no capture and no PC change.
- `IR` changes only on the REQ→LOAD edge.

## Timing
- The instruction register samples `IR`/`IL` on the falling clock edge. `IL` and `IR` are therefore stable from the rising edge that enters LOAD through the next rising edge, which covers exactly one falling edge. The instruction register captures each word exactly once.
- Reset deasserts before edge 0:
  - Edge 1: REQ, `mem_req` rises.
  - With zero-wait memory (`mem_ack` high in the first REQ cycle): edge 2 enters LOAD, `IL` high during cycle 2.
  - Edge 3: HOLD.
- Request-to-load latency, with `next` or `branch_en` sampled at edge n and zero-wait memory:
  - Edge n+1: LOAD.
  - Edge n+2: HOLD.
  - Each memory wait cycle adds one cycle.
- Reset mid-fetch, sampled at any edge: the unit enters IDLE and `mem_req` drops in the following cycle. An ack arriving in that cycle is ignored. The in-flight word is discarded, and `IR` reads 0.
- `pc` updates on the ack edge, so in HOLD `pc` already points past the word on `IR`.

## Test plan
- Reset then zero-wait memory returning 0x1234 at address 0x00 -> `mem_req` high cycle 1; `IR`=0x1234 with `IL` high only in cycle 2; `pc`=0x01 in HOLD; `busy`=0 from cycle 3.
- Memory holds `mem_ack` low for 3 REQ cycles -> `mem_addr` stable; `IL` stays 0 until the ack edge; exactly one `IL` pulse.
- Hold `pc`=0xFF, then `next` -> fetch from 0xFF; `pc` wraps to 0x00.
- In HOLD, assert `branch_en`=1 with `branch_target`=0x40 and `next`=1 together -> fetch from 0x40; `pc`=0x41 afterwards. Then assert `halt`=1 with `branch_en`=1 -> HALTED, no `mem_req`, `pc` unchanged.
- Pulse `next`/`branch_en` while `busy`=1, and pulse `mem_ack` in HOLD -> no state, `IR` or `pc` change.
- Assert `reset` during a REQ wait, with ack arriving one cycle later -> `mem_req` drops; `IR`=0, `pc`=RESET_PC; a fresh fetch from RESET_PC follows deassertion.
